// File: rtl/mul_seq_defs_pkg.sv
// rtl/mul_seq_defs_pkg.sv - shared state encodings and digit constants for mul_sequencer
package mul_seq_defs_pkg;

    localparam int MUL_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] DIGIT_ZERO       = 4'h0;
    localparam logic [3:0] NEG_CODE_DEFAULT = 4'h1;

    localparam int ITER_LAST = MUL_WIDTH - 1;

endpackage

// File: rtl/shift_add_step.sv
// rtl/shift_add_step.sv - one combinational shift-add multiply iteration
module shift_add_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] mq_next
);

    logic [WIDTH:0] sum;

    // acc stays below 2^WIDTH after each shift, so the add never overflows WIDTH+1 bits
    always_comb begin
        sum      = mq[0] ? (acc + {1'b0, mcand}) : acc;
        acc_next = {1'b0, sum[WIDTH:1]};
        mq_next  = {sum[0], mq[WIDTH-1:1]};
    end

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - sequential sign-magnitude multiplier driving display digits (option: MUL_SEQ_ZERO_SIGN_CLEAR_EN)
module mul_sequencer
    import mul_seq_defs_pkg::*;
#(
    parameter int         WIDTH    = MUL_WIDTH,
    parameter logic [3:0] NEG_CODE = NEG_CODE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signX,
    input  logic [WIDTH-1:0] operandX,
    input  logic             signY,
    input  logic [WIDTH-1:0] operandY,
    output logic             busy,
    output logic             done,
    output logic [3:0]       d1,
    output logic [3:0]       d2,
    output logic [3:0]       d3,
    output logic [3:0]       d4,
    output logic [3:0]       d5,
    output logic [3:0]       d6
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;
    logic             sgn;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] mq_next;
    logic             accept;
    logic             neg_result;

    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .mq       (mq),
        .mcand    (mcand),
        .acc_next (acc_next),
        .mq_next  (mq_next)
    );

    // The edge that leaves DONE may take a new request, giving one op per 5 cycles
    always_comb begin
        accept = start && ((state == ST_IDLE) || (state == ST_DONE));
`ifdef MUL_SEQ_ZERO_SIGN_CLEAR_EN
        neg_result = sgn && ({acc_next[WIDTH-1:0], mq_next} != '0);
`else
        neg_result = sgn;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            acc   <= '0;
            mq    <= '0;
            mcand <= '0;
            sgn   <= 1'b0;
            done  <= 1'b0;
            d3    <= DIGIT_ZERO;
            d5    <= DIGIT_ZERO;
            d6    <= DIGIT_ZERO;
        end else begin
            done <= 1'b0;
            if (accept) begin
                mcand <= operandX;
                mq    <= operandY;
                sgn   <= signX ^ signY;
                acc   <= '0;
                count <= '0;
                state <= ST_CALC;
            end else begin
                case (state)
                    ST_CALC: begin
                        acc   <= acc_next;
                        mq    <= mq_next;
                        count <= count + 1'b1;
                        if (count == CW'(ITER_LAST)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            d3    <= neg_result ? NEG_CODE : DIGIT_ZERO;
                            d5    <= acc_next[3:0];
                            d6    <= mq_next[3:0];
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy = (state != ST_IDLE);
    assign d1   = DIGIT_ZERO;
    assign d2   = DIGIT_ZERO;
    assign d4   = DIGIT_ZERO;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - randomized and directed bench for mul_sequencer against a product/timeline model
module tb_mul_sequencer;

    localparam logic [3:0] NEG = 4'h1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       signX, signY;
    logic [3:0] operandX, operandY;
    logic       busy, done;
    logic [3:0] d1, d2, d3, d4, d5, d6;

    mul_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .signX    (signX),
        .operandX (operandX),
        .signY    (signY),
        .operandY (operandY),
        .busy     (busy),
        .done     (done),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .d4       (d4),
        .d5       (d5),
        .d6       (d6)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int done_seen   = 0;

    // model: an op lives for 5 edges after acceptance; its product lands on the 4th
    bit         active  = 1'b0;
    int         op_age  = 0;
    int         pend_prod;
    bit         pend_neg;
    logic [3:0] e_d3 = 4'h0, e_d5 = 4'h0, e_d6 = 4'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        active = 1'b0;
        op_age = 0;
        e_d3 = 4'h0;
        e_d5 = 4'h0;
        e_d6 = 4'h0;
    endtask

    task automatic check_outputs();
        check("busy", busy, active && op_age < 5);
        check("done", done, active && op_age == 4);
        check("d1", d1, 0);
        check("d2", d2, 0);
        check("d3", d3, e_d3);
        check("d4", d4, 0);
        check("d5", d5, e_d5);
        check("d6", d6, e_d6);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            if (active) op_age++;
            if (start && (!active || op_age >= 5)) begin
                active    = 1'b1;
                op_age    = 0;
                pend_prod = int'(operandX) * int'(operandY);
                pend_neg  = signX ^ signY;
`ifdef MUL_SEQ_ZERO_SIGN_CLEAR_EN
                if (pend_prod == 0) pend_neg = 1'b0;
`endif
            end
            if (active && op_age == 4) begin
                e_d3 = pend_neg ? NEG : 4'h0;
                e_d5 = 4'((pend_prod / 16) % 16);
                e_d6 = 4'(pend_prod % 16);
            end
        end
        #1;
        if (done === 1'b1) done_seen++;
        check_outputs();
    endtask

    task automatic run_op(input bit sx, input logic [3:0] x, input bit sy, input logic [3:0] y,
                          input bit zero_after);
        signX = sx; operandX = x; signY = sy; operandY = y; start = 1'b1;
        tick();
        start = 1'b0;
        if (zero_after) begin
            operandX = 4'h0; operandY = 4'h0; signX = 1'b0; signY = 1'b1;
        end
        repeat (5) tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        signX = 1'b0; signY = 1'b0; operandX = 4'h0; operandY = 4'h0;
        repeat (2) tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 1'b0;
        tick();

        // +7 * -9 = -63
        run_op(1'b0, 4'd7, 1'b1, 4'd9, 1'b0);
        check("p63_d3", d3, 4'h1);
        check("p63_d5", d5, 4'h3);
        check("p63_d6", d6, 4'hF);

        // -15 * -15 = 225, inputs cleared after the start edge
        run_op(1'b1, 4'd15, 1'b1, 4'd15, 1'b1);
        check("p225_d3", d3, 4'h0);
        check("p225_d5", d5, 4'hE);
        check("p225_d6", d6, 4'h1);

        // +0 * -13 = zero with differing signs
        run_op(1'b0, 4'd0, 1'b1, 4'd13, 1'b0);
        check("zero_d5", d5, 4'h0);
        check("zero_d6", d6, 4'h0);
`ifdef MUL_SEQ_ZERO_SIGN_CLEAR_EN
        check("zero_d3", d3, 4'h0);
`else
        check("zero_d3", d3, 4'h1);
`endif

        // start held high: ops at edges 0, 5, 10 only
        done_seen = 0;
        signX = 1'b0; operandX = 4'd3; signY = 1'b0; operandY = 4'd5; start = 1'b1;
        repeat (15) tick();
        start = 1'b0;
        repeat (3) tick();
        check("held_start_dones", done_seen, 3);
        check("held_d5", d5, 4'h0);
        check("held_d6", d6, 4'hF);

        // restore 63, then 2*2 must keep 3/F on display until done
        run_op(1'b0, 4'd7, 1'b1, 4'd9, 1'b0);
        signX = 1'b0; operandX = 4'd2; signY = 1'b0; operandY = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("hold_d5", d5, 4'h3);
        check("hold_d6", d6, 4'hF);
        tick();
        check("new_d5", d5, 4'h0);
        check("new_d6", d6, 4'h4);
        tick();

        // asynchronous reset between edges 2 and 3 of an op
        signX = 1'b1; operandX = 4'd11; signY = 1'b0; operandY = 4'd6; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        #2 reset = 1'b1;
        #1;
        model_clear();
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_d3", d3, 0);
        check("arst_d5", d5, 0);
        check("arst_d6", d6, 0);
        tick();
        reset = 1'b0;
        done_seen = 0;
        repeat (6) tick();
        check("arst_no_done", done_seen, 0);
        run_op(1'b1, 4'd11, 1'b0, 4'd6, 1'b0);
        check("after_rst_d5", d5, 4'h4);
        check("after_rst_d6", d6, 4'h2);

        // random traffic, operands churn every cycle
        for (int i = 0; i < 400; i++) begin
            start    = ($urandom_range(0, 2) == 0);
            signX    = 1'($urandom);
            signY    = 1'($urandom);
            operandX = 4'($urandom);
            operandY = 4'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
